// File: rtl/seg7_scan_n.sv
// Multiplexed seven-segment scanner with frame-aligned double-buffered load,
// live leading-zero suppression and PWM brightness.
module seg7_scan_n #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_PERIOD = 200_000,
  parameter int BRIGHT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    load_i,
  input  logic                    lz_en_i,
  input  logic [BRIGHT_W-1:0]     bright_i,
  output logic                    busy_o,
  output logic [6:0]              CAT,
  output logic                    DP_o,
  output logic [NUM_DIGITS-1:0]   AN
);

  localparam int CNT_W = $clog2(DIGIT_PERIOD);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
  logic                    busy_q, busy_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              cat_q, cat_d;
  logic                    dp_q, dp_d;

  logic                    tick, last, frame_end;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              nib;
  logic                    dp_bit, blk, lzb, dark;
  logic [6:0]              seg;

  always_comb begin
    tick      = (cnt_q == CNT_W'(DIGIT_PERIOD - 1));
    last      = (idx_q == IDX_W'(NUM_DIGITS - 1));
    frame_end = tick && last;
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (tick) idx_d = last ? '0 : idx_q + IDX_W'(1);
    pwm_d        = pwm_q + BRIGHT_W'(1);
    busy_d       = busy_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    // Promotion and a fresh capture may share the frame_end cycle.
    if (frame_end && busy_q) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
      busy_d      = 1'b0;
    end
    if (load_i && !busy_q) begin
      pend_data_d  = data_i;
      pend_dp_d    = dp_i;
      pend_blank_d = blank_i;
      busy_d       = 1'b1;
    end
  end

  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero    = all_zero && (act_data_q[4*k +: 4] == 4'h0);
      lz_blank[k] = lz_en_i && (k != 0) && all_zero;
    end
  end

  always_comb begin
    nib    = '0;
    dp_bit = 1'b0;
    blk    = 1'b0;
    lzb    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib    = act_data_q[4*i +: 4];
        dp_bit = act_dp_q[i];
        blk    = act_blank_q[i];
        lzb    = lz_blank[i];
      end
    end
    dark = blk | lzb | (pwm_q > bright_i);
    unique case (nib)
      4'h0: seg = 7'h01;
      4'h1: seg = 7'h4F;
      4'h2: seg = 7'h12;
      4'h3: seg = 7'h06;
      4'h4: seg = 7'h4C;
      4'h5: seg = 7'h24;
      4'h6: seg = 7'h20;
      4'h7: seg = 7'h0F;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h04;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h60;
      4'hC: seg = 7'h31;
      4'hD: seg = 7'h42;
      4'hE: seg = 7'h30;
      4'hF: seg = 7'h38;
      default: seg = 7'h7F;
    endcase
    an_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      an_d[i] = dark | (idx_q != IDX_W'(i));
    cat_d = dark ? 7'h7F : seg;
    dp_d  = dark | ~dp_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      busy_q       <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      an_q         <= '1;
      cat_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      busy_q       <= busy_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      an_q         <= an_d;
      cat_q        <= cat_d;
      dp_q         <= dp_d;
    end
  end

  assign busy_o = busy_q;
  assign AN     = an_q;
  assign CAT    = cat_q;
  assign DP_o   = dp_q;

endmodule

// File: tb/tb_seg7_scan_n.sv
// Directed bench for seg7_scan_n: a 4-digit instance and a 1-digit
// instance, both with 4-cycle slots and 2-bit brightness.
module tb_seg7_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  dp, blank;
  logic        load, lz_en;
  logic [1:0]  bright;
  logic        busy;
  logic [6:0]  cat;
  logic        dpo;
  logic [3:0]  an;

  logic [3:0]  data1;
  logic        dp1, blank1, load1, lz_en1;
  logic [1:0]  bright1;
  logic        busy1;
  logic [6:0]  cat1;
  logic        dpo1;
  logic        an1;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] SEG [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  seg7_scan_n #(.NUM_DIGITS(4), .DIGIT_PERIOD(4), .BRIGHT_W(2)) dut (
    .clk(clk), .rst_n_i(rst_n), .data_i(data), .dp_i(dp),
    .blank_i(blank), .load_i(load), .lz_en_i(lz_en),
    .bright_i(bright), .busy_o(busy), .CAT(cat), .DP_o(dpo), .AN(an));

  seg7_scan_n #(.NUM_DIGITS(1), .DIGIT_PERIOD(4), .BRIGHT_W(2)) dut1 (
    .clk(clk), .rst_n_i(rst_n), .data_i(data1), .dp_i(dp1),
    .blank_i(blank1), .load_i(load1), .lz_en_i(lz_en1),
    .bright_i(bright1), .busy_o(busy1), .CAT(cat1), .DP_o(dpo1),
    .AN(an1));

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge just before the first scanning edge (E0).
  task automatic do_reset;
    rst_n = 1'b0;
    data = '0; dp = '0; blank = '0; load = 1'b0; lz_en = 1'b0;
    bright = 2'd3;
    data1 = '0; dp1 = 1'b0; blank1 = 1'b0; load1 = 1'b0;
    lz_en1 = 1'b0; bright1 = 2'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [3:0] ea;
    int idx;
    do_reset;
    rst_n = 1'b0;
    data = 16'hFFFF; load = 1'b1;
    step; step;
    checks++; if (an !== 4'hF) begin errors++;
      $display("FAIL rst_an got %b want 1111", an); end
    checks++; if (cat !== 7'h7F) begin errors++;
      $display("FAIL rst_cat got %h want 7f", cat); end
    checks++; if (dpo !== 1'b1) begin errors++;
      $display("FAIL rst_dp got %b want 1", dpo); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (an1 !== 1'b1 || cat1 !== 7'h7F) begin errors++;
      $display("FAIL rst_d1 got an %b cat %h want 1 7f", an1, cat1); end
    rst_n = 1'b1; load = 1'b0; data = '0;
    for (int k = 0; k < 16; k++) begin
      step;
      idx = k / 4;
      ea = ~(4'b0001 << idx);
      checks++; if (an !== ea || cat !== 7'h01) begin errors++;
        $display("FAIL post_rst k%0d got an %b cat %h want %b 01",
                 k, an, cat, ea); end
    end
  endtask

  task automatic test_scan;
    logic [15:0] ed;
    logic [3:0] ea;
    int idx;
    do_reset;
    ed = 16'h1234;
    data = ed; load = 1'b1;
    step;
    load = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL scan_busy_set got %b want 1", busy); end
    for (int k = 1; k < 16; k++) step;
    checks++; if (busy !== 1'b0 || an !== 4'b0111 || cat !== 7'h01) begin
      errors++;
      $display("FAIL scan_e15 got busy %b an %b cat %h want 0 0111 01",
               busy, an, cat); end
    for (int k = 16; k < 32; k++) begin
      step;
      idx = (k / 4) % 4;
      ea = ~(4'b0001 << idx);
      checks++;
      if (an !== ea || cat !== SEG[ed[idx*4 +: 4]] || dpo !== 1'b1) begin
        errors++;
        $display("FAIL scan k%0d got an %b cat %h dp %b want %b %h 1",
                 k, an, cat, dpo, ea, SEG[ed[idx*4 +: 4]]); end
    end
  endtask

  task automatic test_busy_ignore;
    logic [15:0] ed;
    logic [3:0] ea;
    int idx;
    do_reset;
    ed = 16'h1234;
    data = ed; load = 1'b1;
    step;
    load = 1'b0;
    step; step;
    data = 16'hABCD; load = 1'b1;
    step;
    load = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL ign_busy got %b want 1", busy); end
    for (int k = 4; k < 16; k++) step;
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL ign_busy_clr got %b want 0", busy); end
    for (int k = 16; k < 48; k++) begin
      step;
      idx = (k / 4) % 4;
      ea = ~(4'b0001 << idx);
      checks++; if (an !== ea || cat !== SEG[ed[idx*4 +: 4]]) begin
        errors++;
        $display("FAIL ign k%0d got an %b cat %h want %b %h",
                 k, an, cat, ea, SEG[ed[idx*4 +: 4]]); end
    end
  endtask

  task automatic test_load_frame_end;
    logic [15:0] ed;
    logic [3:0] ea;
    int idx;
    do_reset;
    ed = 16'h5678;
    data = ed;
    for (int k = 0; k < 15; k++) step;
    load = 1'b1;
    step;
    load = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL lfe_busy got %b want 1", busy); end
    for (int k = 16; k < 32; k++) begin
      step;
      checks++; if (cat !== 7'h01) begin errors++;
        $display("FAIL lfe_old k%0d got cat %h want 01", k, cat); end
    end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL lfe_busy_clr got %b want 0", busy); end
    for (int k = 32; k < 48; k++) begin
      step;
      idx = (k / 4) % 4;
      ea = ~(4'b0001 << idx);
      checks++; if (an !== ea || cat !== SEG[ed[idx*4 +: 4]]) begin
        errors++;
        $display("FAIL lfe_new k%0d got an %b cat %h want %b %h",
                 k, an, cat, ea, SEG[ed[idx*4 +: 4]]); end
    end
  endtask

  task automatic test_lz;
    logic [3:0] ea [4];
    logic [6:0] ec [4];
    int idx;
    ea = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    ec = '{7'h01, 7'h24, 7'h7F, 7'h7F};
    do_reset;
    lz_en = 1'b1;
    data = 16'h0050; load = 1'b1;
    step;
    load = 1'b0;
    for (int k = 1; k < 16; k++) step;
    for (int k = 16; k < 32; k++) begin
      step;
      idx = (k / 4) % 4;
      checks++; if (an !== ea[idx] || cat !== ec[idx]) begin errors++;
        $display("FAIL lz k%0d got an %b cat %h want %b %h",
                 k, an, cat, ea[idx], ec[idx]); end
    end
    lz_en = 1'b0;
    for (int k = 32; k < 48; k++) begin
      step;
      if (k >= 44) begin
        checks++; if (an !== 4'b0111 || cat !== 7'h01) begin errors++;
          $display("FAIL lz_off k%0d got an %b cat %h want 0111 01",
                   k, an, cat); end
      end
    end
  endtask

  task automatic test_bright;
    logic [15:0] ed;
    logic [3:0] ea;
    logic [6:0] ec;
    logic lit;
    int idx;
    do_reset;
    bright = 2'd0;
    ed = 16'h1234;
    data = ed; load = 1'b1;
    step;
    load = 1'b0;
    for (int k = 1; k < 16; k++) step;
    for (int k = 16; k < 32; k++) begin
      step;
      idx = (k / 4) % 4;
      lit = (k % 4 == 0);
      ea = lit ? ~(4'b0001 << idx) : 4'hF;
      ec = lit ? SEG[ed[idx*4 +: 4]] : 7'h7F;
      checks++; if (an !== ea || cat !== ec) begin errors++;
        $display("FAIL bright0 k%0d got an %b cat %h want %b %h",
                 k, an, cat, ea, ec); end
    end
    bright = 2'd1;
    for (int k = 32; k < 48; k++) begin
      step;
      idx = (k / 4) % 4;
      lit = (k % 4 <= 1);
      ea = lit ? ~(4'b0001 << idx) : 4'hF;
      checks++; if (an !== ea) begin errors++;
        $display("FAIL bright1 k%0d got an %b want %b", k, an, ea); end
    end
  endtask

  task automatic test_blank_dp;
    logic [3:0] ea [4];
    logic [6:0] ec [4];
    logic       ep [4];
    int idx;
    ea = '{4'b1110, 4'b1111, 4'b1011, 4'b0111};
    ec = '{7'h38, 7'h7F, 7'h04, 7'h00};
    ep = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset;
    data = 16'h89EF; dp = 4'b0101; blank = 4'b0010; load = 1'b1;
    step;
    load = 1'b0;
    for (int k = 1; k < 16; k++) step;
    for (int k = 16; k < 32; k++) begin
      step;
      idx = (k / 4) % 4;
      checks++;
      if (an !== ea[idx] || cat !== ec[idx] || dpo !== ep[idx]) begin
        errors++;
        $display("FAIL blkdp k%0d got an %b cat %h dp %b want %b %h %b",
                 k, an, cat, dpo, ea[idx], ec[idx], ep[idx]); end
    end
  endtask

  task automatic test_reset_midframe;
    logic [3:0] ea;
    int idx;
    do_reset;
    data = 16'h1234; load = 1'b1;
    step;
    load = 1'b0;
    for (int k = 1; k < 10; k++) step;
    checks++; if (busy !== 1'b1 || an !== 4'b1011) begin errors++;
      $display("FAIL mid_pre got busy %b an %b want 1 1011", busy, an); end
    rst_n = 1'b0;
    step;
    checks++;
    if (an !== 4'hF || cat !== 7'h7F || busy !== 1'b0 || dpo !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst got an %b cat %h busy %b dp %b want 1111 7f 0 1",
               an, cat, busy, dpo); end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step;
      idx = (k / 4) % 4;
      ea = ~(4'b0001 << idx);
      checks++; if (an !== ea || cat !== 7'h01) begin errors++;
        $display("FAIL mid_post k%0d got an %b cat %h want %b 01",
                 k, an, cat, ea); end
    end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL mid_busy got %b want 0", busy); end
  endtask

  task automatic test_single;
    logic lit;
    do_reset;
    data1 = 4'h7; load1 = 1'b1;
    step;
    load1 = 1'b0;
    checks++; if (busy1 !== 1'b1 || cat1 !== 7'h01 || an1 !== 1'b0) begin
      errors++;
      $display("FAIL one_e0 got busy %b cat %h an %b want 1 01 0",
               busy1, cat1, an1); end
    step; step; step;
    checks++; if (busy1 !== 1'b0) begin errors++;
      $display("FAIL one_busy got %b want 0", busy1); end
    for (int k = 4; k < 12; k++) begin
      step;
      checks++; if (an1 !== 1'b0 || cat1 !== 7'h0F || dpo1 !== 1'b1) begin
        errors++;
        $display("FAIL one k%0d got an %b cat %h dp %b want 0 0f 1",
                 k, an1, cat1, dpo1); end
    end
    bright1 = 2'd0;
    for (int k = 12; k < 20; k++) begin
      step;
      lit = (k % 4 == 0);
      checks++;
      if (an1 !== !lit || cat1 !== (lit ? 7'h0F : 7'h7F)) begin errors++;
        $display("FAIL one_pwm k%0d got an %b cat %h lit %b",
                 k, an1, cat1, lit); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    data = '0; dp = '0; blank = '0; load = 1'b0; lz_en = 1'b0;
    bright = 2'd3;
    data1 = '0; dp1 = 1'b0; blank1 = 1'b0; load1 = 1'b0;
    lz_en1 = 1'b0; bright1 = 2'd3;
    test_reset;
    test_scan;
    test_busy_ignore;
    test_load_frame_end;
    test_lz;
    test_bright;
    test_blank_dp;
    test_reset_midframe;
    test_single;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_n.md
SEG7_SCAN_N -- requirements
Module: seg7_scan_n

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (legal 1..16).
REQ-002 SHALL have parameter DIGIT_PERIOD, default 200_000, clock cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter BRIGHT_W, default 4, brightness PWM resolution in bits (legal 1..8).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1, synchronous active-low reset.
REQ-006 SHALL have port data_i, input, 4*NUM_DIGITS, hex nibbles; digit i = data_i[4i+3:4i].
REQ-007 SHALL have port dp_i, input, NUM_DIGITS, decimal point per digit, 1 = lit.
REQ-008 SHALL have port blank_i, input, NUM_DIGITS, forced blank per digit, 1 = blank.
REQ-009 SHALL have port load_i, input, 1, one-cycle strobe capturing data_i, dp_i and blank_i.
REQ-010 SHALL have port lz_en_i, input, 1, leading-zero suppression enable, applied live.
REQ-011 SHALL have port bright_i, input, BRIGHT_W, brightness level, applied live.
REQ-012 SHALL have port busy_o, output, 1, high while a captured load awaits the frame boundary.
REQ-013 SHALL have port CAT, output, 7, segments a..g (a = MSB), active low, registered.
REQ-014 SHALL have port DP_o, output, 1, decimal point, active low, registered.
REQ-015 SHALL have port AN, output, NUM_DIGITS, digit anodes, active low, one-hot-low, registered.

Function
REQ-016 SHALL run slot counter cnt 0..DIGIT_PERIOD-1; tick = (cnt == DIGIT_PERIOD-1), cnt then wraps to 0.
REQ-017 SHALL advance digit index idx by 1 on each tick, wrapping NUM_DIGITS-1 -> 0; frame_end = tick with idx == NUM_DIGITS-1.
REQ-018 SHALL hold pending and active copies of data/dp/blank; display uses active copy only.
REQ-019 SHALL, on load_i=1 with busy_o=0, capture inputs into pending and set busy_o=1 next cycle.
REQ-020 SHALL ignore load_i while busy_o=1; pending is not overwritten.
REQ-021 SHALL, on frame_end with busy_o=1, copy pending to active and clear busy_o next cycle; new data first shown at idx 0.
REQ-022 SHALL, on load_i coinciding with frame_end while busy_o=0, capture to pending only; it applies at the following frame_end.
REQ-023 SHALL run free BRIGHT_W-bit PWM counter pwm incrementing every cycle with wrap; digit lit only when pwm <= bright_i.
REQ-024 SHALL treat digit k as LZ-blank when lz_en_i=1, k != 0, and active nibbles k..NUM_DIGITS-1 are all zero.
REQ-025 SHALL treat digit idx as dark when active blank bit is set, LZ-blank, or PWM-off; dark -> AN all ones, CAT 7'h7F, DP_o 1.
REQ-026 SHALL otherwise drive AN with bit idx low only, DP_o = ~active dp[idx], CAT = code of active nibble idx.
REQ-027 SHALL use segment codes (hex of CAT) 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F 8:00 9:04 A:08 B:60 C:31 D:42 E:30 F:38.
REQ-028 SHALL register AN, CAT, DP_o from the current cnt/idx/pwm state, i.e. one cycle latency from those counters.
REQ-029 SHALL, with NUM_DIGITS=1, keep idx at 0 and make every tick a frame_end.

Reset
REQ-030 SHALL, on rising clk with rst_n_i=0, set cnt=0, idx=0, pwm=0, busy_o=0, pending and active data/dp/blank=0.
REQ-031 SHALL, during reset, drive AN all ones, CAT 7'h7F, DP_o 1, abandoning any pending load.
REQ-032 SHALL, on first cycle after release, begin scanning at idx 0 with cnt 0, displaying all-zero data.

Verification (NUM_DIGITS=4, DIGIT_PERIOD=4, BRIGHT_W=2 unless noted)
REQ-033 SHALL cover: bright_i=3, load 0x1234, dp 0000 -> after next frame_end AN 1110/1101/1011/0111, 4 cycles each, CAT 4C/06/12/4F.
REQ-034 SHALL cover: load 0x1234, then load 0xABCD while busy_o=1 -> 0x1234 displayed, 0xABCD never shown, busy_o low after frame_end.
REQ-035 SHALL cover: lz_en_i=1, active 0x0050 -> slots 3,2 AN=1111 CAT=7F; slot 1 CAT=24; slot 0 CAT=01.
REQ-036 SHALL cover: bright_i=0 -> within each slot AN active exactly 1 of every 4 cycles (pwm==0), dark otherwise.
REQ-037 SHALL cover: rst_n_i=0 mid-frame at idx 2 with busy_o=1 -> next edge AN=1111, CAT=7F, busy_o=0; after release scan restarts at idx 0 showing zeros.
REQ-038 SHALL cover: NUM_DIGITS=1, load 0x7 -> applied at first tick, AN=0 each lit cycle, CAT=0F.
